mem_loader: RTL and testbench

Synthesizable boot loader that fills the multicycle computer's unified instruction/data memory from a byte stream, replacing simulation-only memory initialisation. It accepts a length-prefixed stream of bytes, assembles big-endian 32-bit words, and writes them to consecutive word addresses starting at 0. It holds the CPU in reset until the load completes. It sits between an external byte source (UART receiver or bench) and the memory write port, with its `cpu_rstn` output driving the CPU's active-low `rstn`.

---
 rtl/mccomp_pkg.sv | 23 ++
 rtl/word_assembler.sv | 45 ++++
 rtl/mem_loader.sv | 140 ++++++++++++++
 tb/tb_mem_loader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mccomp_pkg.sv
// ---------------------------------------------------------------------------
// mccomp_pkg
// Shared types and constants for the multicycle computer's boot loader.
//   loader_state_t : state encoding of the mem_loader control FSM
//   WORD_W         : memory word width in bits
//   BYTES_PER_WORD : bytes assembled into one memory word
// ---------------------------------------------------------------------------
package mccomp_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_BYTE,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler
// Shifts incoming bytes into a 32-bit word, most significant byte first.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : synchronous clear of word and byte index (start of a load)
//   shift_en   : accept byte_in this cycle
//   byte_in    : byte to shift in at the bottom of the word
//   word       : assembled word (first byte ends up in word[31:24])
//   word_full  : the current shift supplies the last byte of a word
// ---------------------------------------------------------------------------
module word_assembler
    import mccomp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_full
);

    logic [1:0] byte_idx;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (shift_en) begin
            word     <= {word[WORD_W-9:0], byte_in};
            byte_idx <= byte_idx + 2'd1;
        end
    end

    // The index wraps naturally to 0 after the fourth byte, ready for the
    // next word without an explicit clear.
    assign word_full = shift_en && (byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mem_loader.sv
// ---------------------------------------------------------------------------
// mem_loader
// Boot loader: receives a length-prefixed byte stream (16-bit word count,
// MSB first, then 4 bytes per word, MSB first) and writes the words to
// consecutive memory addresses from 0. Holds the CPU in reset until done.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start               : begin a load (honoured in IDLE, DONE, ERR)
//   in_valid, in_data   : byte source; transfer when in_valid && in_ready
//   in_ready            : loader accepts a byte this cycle
//   mem_we/addr/wdata   : one-cycle word write to memory
//   cpu_rstn            : active-low CPU reset, released only in DONE
//   busy, done, err     : status flags
// ---------------------------------------------------------------------------
module mem_loader
    import mccomp_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_rstn,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    loader_state_t     state, next_state;
    logic [7:0]        len_hi;
    logic [15:0]       remaining;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       len_n;
    logic              xfer;
    logic              shift_en;
    logic              clear_word;
    logic              word_full;
    logic [WORD_W-1:0] word;

    assign xfer     = in_valid && in_ready;
    assign len_n    = {len_hi, in_data};
    assign shift_en = (state == ST_BYTE) && xfer;
    // Entering LEN_HI from IDLE/DONE/ERR starts a fresh word.
    assign clear_word = (next_state == ST_LEN_HI) && (state != ST_LEN_HI);

    word_assembler u_word_assembler (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear_word),
        .shift_en (shift_en),
        .byte_in  (in_data),
        .word     (word),
        .word_full(word_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:   if (start) next_state = ST_LEN_HI;
            ST_LEN_HI: if (xfer) next_state = ST_LEN_LO;
            ST_LEN_LO: begin
                if (xfer) begin
                    if (len_n == 16'd0)                next_state = ST_DONE;
                    else if ({16'd0, len_n} > DEPTH)   next_state = ST_ERR;
                    else                               next_state = ST_BYTE;
                end
            end
            ST_BYTE:   if (word_full) next_state = ST_WRITE;
            ST_WRITE:  next_state = (remaining == 16'd1) ? ST_DONE : ST_BYTE;
            ST_DONE,
            ST_ERR:    if (start) next_state = ST_LEN_HI;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Length, remaining count and write address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_hi    <= '0;
            remaining <= '0;
            addr      <= '0;
        end else begin
            unique case (state)
                ST_LEN_HI: if (xfer) len_hi <= in_data;
                ST_LEN_LO: begin
                    if (xfer) begin
                        remaining <= len_n;
                        addr      <= '0;
                    end
                end
                ST_WRITE: begin
                    // With N == DEPTH this wraps to 0 only after the last write.
                    addr      <= addr + ADDR_W'(1);
                    remaining <= remaining - 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Status outputs are decoded from next_state into flops so they change
    // on the same edge as the state and never depend combinationally on
    // in_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            mem_we   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_rstn <= 1'b0;
        end else begin
            in_ready <= next_state inside {ST_LEN_HI, ST_LEN_LO, ST_BYTE};
            busy     <= next_state inside {ST_LEN_HI, ST_LEN_LO, ST_BYTE, ST_WRITE};
            mem_we   <= (next_state == ST_WRITE);
            done     <= (next_state == ST_DONE);
            err      <= (next_state == ST_ERR);
            cpu_rstn <= (next_state == ST_DONE);
        end
    end

    assign mem_addr  = addr;
    assign mem_wdata = word;

endmodule

// File: tb/tb_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_mem_loader
// Directed and randomized loads against mem_loader. Expected writes are
// derived from the word list each load is built from: word i goes to
// address i mod DEPTH, and a gap-free load finishes 2 + 5*N cycles after
// start.
// ---------------------------------------------------------------------------
module tb_mem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [31:0] word_q_t[$];

    logic              clk;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rstn;
    logic              busy;
    logic              done;
    logic              err;

    mem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_rstn (cpu_rstn),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: records every write and the cycle done last rose.
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    logic              we_prev = 1'b0;
    logic              done_prev = 1'b0;
    int                done_rise_cyc = 0;
    int                we_long = 0;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            if (we_prev) we_long <= we_long + 1;
        end
        we_prev   <= mem_we;
        done_prev <= done;
        if (done && !done_prev) done_rise_cyc <= cyc;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic do_start(output int t);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = cyc;
    endtask

    // Offers bytes from a negedge, with random idle cycles; optionally pulses
    // start once when byte index start_at is being offered.
    task automatic send_bytes(input byte_q_t bq, input int gap, input int start_at);
        int idx = 0;
        int budget = 0;
        bit pulsed = 1'b0;
        bit v;
        bit acc;
        while (idx < bq.size() && budget < 5000) begin
            v = ($urandom_range(99) >= gap);
            in_valid = v;
            in_data  = v ? bq[idx] : 8'($urandom);
            start    = (start_at >= 0) && (idx == start_at) && !pulsed;
            if (start) pulsed = 1'b1;
            acc = v && in_ready;
            @(negedge clk);
            if (acc) idx++;
            budget++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (idx < bq.size()) check("stream_stalled", idx, bq.size());
    endtask

    task automatic wait_end(input int max_cyc);
        int k = 0;
        while (!(done || err) && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        if (!(done || err)) check("end_timeout", 32'(done | err), 1);
        @(negedge clk);
    endtask

    task automatic run_load(input string tag, input word_q_t words, input int gap, input int start_at);
        byte_q_t bq;
        int n;
        int base;
        int t0;
        n    = words.size();
        base = wr_addr_q.size();
        bq.push_back(8'(n >> 8));
        bq.push_back(8'(n));
        foreach (words[i])
            for (int b = 3; b >= 0; b--) bq.push_back(8'(words[i] >> (8 * b)));
        do_start(t0);
        check({tag, "/in_ready_after_start"}, 32'(in_ready), 1);
        check({tag, "/cpu_held_in_reset"}, 32'(cpu_rstn), 0);
        send_bytes(bq, gap, start_at);
        wait_end(100);
        check({tag, "/done"}, 32'(done), 1);
        check({tag, "/cpu_rstn"}, 32'(cpu_rstn), 1);
        check({tag, "/err"}, 32'(err), 0);
        check({tag, "/idle_outputs"}, {30'd0, in_ready, busy}, 0);
        check({tag, "/write_count"}, wr_addr_q.size() - base, n);
        for (int i = 0; i < n && base + i < wr_addr_q.size(); i++) begin
            check({tag, "/addr"}, 32'(wr_addr_q[base + i]), 32'(i % DEPTH));
            check({tag, "/data"}, wr_data_q[base + i], words[i]);
        end
        if (gap == 0) check({tag, "/done_latency"}, done_rise_cyc - t0, 2 + 5 * n);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/in_ready"}, 32'(in_ready), 0);
        check({tag, "/mem_we"}, 32'(mem_we), 0);
        check({tag, "/mem_addr"}, 32'(mem_addr), 0);
        check({tag, "/mem_wdata"}, mem_wdata, 0);
        check({tag, "/cpu_rstn"}, 32'(cpu_rstn), 0);
        check({tag, "/busy"}, 32'(busy), 0);
        check({tag, "/done"}, 32'(done), 0);
        check({tag, "/err"}, 32'(err), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        word_q_t basic;
        word_q_t empty;
        word_q_t w;
        byte_q_t bq;
        int base;
        int t0;

        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle/in_ready", 32'(in_ready), 0);

        // Basic two-word load.
        basic.push_back(32'h12345678);
        basic.push_back(32'h9ABCDEF0);
        run_load("basic", basic, 0, -1);

        // Zero-length load: DONE right after the count bytes.
        empty.delete();
        run_load("zero", empty, 0, -1);

        // Oversize count (257 > 256) ends in ERR without writes.
        base = wr_addr_q.size();
        bq.delete();
        bq.push_back(8'h01);
        bq.push_back(8'h01);
        do_start(t0);
        send_bytes(bq, 0, -1);
        wait_end(20);
        check("oversize/err", 32'(err), 1);
        check("oversize/done", 32'(done), 0);
        check("oversize/cpu_rstn", 32'(cpu_rstn), 0);
        check("oversize/in_ready", 32'(in_ready), 0);
        check("oversize/busy", 32'(busy), 0);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (3) @(negedge clk);
        check("oversize/in_ready_offered", 32'(in_ready), 0);
        check("oversize/err_held", 32'(err), 1);
        in_valid = 1'b0;
        check("oversize/no_writes", wr_addr_q.size() - base, 0);
        w.delete();
        w.push_back($urandom);
        run_load("after_err", w, 0, -1);

        // Same data as the basic load, source idle half the time.
        run_load("gaps", basic, 50, -1);

        // Random lengths, data and stall rates.
        for (int r = 0; r < 4; r++) begin
            w.delete();
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) w.push_back($urandom);
            run_load("random", w, int'($urandom_range(0, 60)), -1);
        end

        // Full-depth load with a start pulse in the middle of word 1.
        w.delete();
        for (int i = 0; i < DEPTH; i++) w.push_back($urandom);
        run_load("n256", w, 0, 8);

        // Reset after five data bytes: outputs clear at once, word 0 written.
        w.delete();
        w.push_back($urandom);
        w.push_back($urandom);
        bq.delete();
        bq.push_back(8'h00);
        bq.push_back(8'h02);
        for (int b = 3; b >= 0; b--) bq.push_back(8'(w[0] >> (8 * b)));
        bq.push_back(8'(w[1] >> 24));
        base = wr_addr_q.size();
        do_start(t0);
        send_bytes(bq, 0, -1);
        #1 rst = 1'b1;
        #1 check_reset_outputs("midload_rst");
        check("midload_rst/write_count", wr_addr_q.size() - base, 1);
        if (wr_addr_q.size() > base) begin
            check("midload_rst/w0_addr", 32'(wr_addr_q[base]), 0);
            check("midload_rst/w0_data", wr_data_q[base], w[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        w.delete();
        w.push_back($urandom);
        run_load("after_rst", w, 0, -1);

        check("mem_we_single_cycle", we_long, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
